// File: rtl/calc_pkg.sv
// Shared calculator definitions: key codes, keypad map and scanner state encoding.
package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_DIV = 4'd13;
  localparam logic [3:0] KEY_CLR = 4'd14;
  localparam logic [3:0] KEY_EQ  = 4'd15;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, RELEASE} scan_state_e;

  // idx = row*4 + col; rows read "1 2 3 A", "4 5 6 B", "7 8 9 C", "* 0 # D"
  function automatic logic [3:0] key_map(input logic [3:0] idx);
    logic [3:0] v;
    case (idx)
      4'd0:  v = 4'd1;
      4'd1:  v = 4'd2;
      4'd2:  v = 4'd3;
      4'd3:  v = KEY_ADD;
      4'd4:  v = 4'd4;
      4'd5:  v = 4'd5;
      4'd6:  v = 4'd6;
      4'd7:  v = KEY_SUB;
      4'd8:  v = 4'd7;
      4'd9:  v = 4'd8;
      4'd10: v = 4'd9;
      4'd11: v = KEY_MUL;
      4'd12: v = KEY_CLR;
      4'd13: v = 4'd0;
      4'd14: v = KEY_EQ;
      default: v = KEY_DIV;
    endcase
    return v;
  endfunction

  // Column index of the low bit; only meaningful when exactly one bit is low.
  function automatic logic [1:0] low_idx(input logic [3:0] cols);
    logic [1:0] i;
    case (cols)
      4'b1110: i = 2'd0;
      4'b1101: i = 2'd1;
      4'b1011: i = 2'd2;
      default: i = 2'd3;
    endcase
    return i;
  endfunction

  function automatic logic [3:0] row_drive(input logic [1:0] r);
    return ~(4'b0001 << r);
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchroniser for asynchronous inputs; resets to all-ones (idle columns).
module sync2 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row scan, debounced press/release, one event per press.
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 500,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic       key_valid,
  output logic [3:0] key_value,
  output logic       key_is_digit,
  output logic       key_held
);

  localparam int CMAX = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] DEB_LAST    = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    col_s;
  scan_state_e   state;
  logic [CW-1:0] cnt;
  logic [1:0]    row;
  logic [1:0]    cap_col;
  logic [3:0]    cap_pat;
  logic          one_low;
  logic [3:0]    hit_val;

  sync2 #(.W(4)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (col_n),
    .q   (col_s)
  );

  // More than one low column is treated as ghosting and skipped.
  assign one_low = ($countones(~col_s) == 1);
  assign hit_val = key_map({row, cap_col});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= SCAN;
      cnt          <= '0;
      row          <= 2'd0;
      row_n        <= 4'b1110;
      cap_col      <= 2'd0;
      cap_pat      <= 4'hF;
      key_valid    <= 1'b0;
      key_value    <= 4'd0;
      key_is_digit <= 1'b0;
      key_held     <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (cnt == SETTLE_LAST) begin
            cnt <= '0;
            if (one_low) begin
              cap_pat <= col_s;
              cap_col <= low_idx(col_s);
              state   <= DEBOUNCE;
            end else begin
              row   <= row + 2'd1;
              row_n <= row_drive(row + 2'd1);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (col_s != cap_pat) begin
            cnt   <= '0;
            row   <= row + 2'd1;
            row_n <= row_drive(row + 2'd1);
            state <= SCAN;
          end else if (cnt == DEB_LAST) begin
            cnt   <= '0;
            state <= EMIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        EMIT: begin
          key_valid    <= 1'b1;
          key_value    <= hit_val;
          key_is_digit <= (hit_val <= 4'd9);
          key_held     <= 1'b1;
          cnt          <= '0;
          state        <= RELEASE;
        end
        RELEASE: begin
          // Row stays on the held key, so other keys cannot start an event.
          if (col_s != 4'hF) begin
            cnt <= '0;
          end else if (cnt == DEB_LAST) begin
            cnt      <= '0;
            key_held <= 1'b0;
            row      <= row + 2'd1;
            row_n    <= row_drive(row + 2'd1);
            state    <= SCAN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, directed table, corner sequences, random presses.
module tb_keypad_scanner;

  localparam int S = 4;
  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col_n, row_n, key_value;
  logic       key_valid, key_is_digit, key_held;
  logic [15:0] pressed = '0;

  int checks = 0;
  int fails  = 0;
  int ev_val[$];
  int ev_dig[$];
  int dbl = 0;
  int noheld = 0;
  logic prev_v = 1'b0;

  always #5 clk = ~clk;

  keypad_scanner #(.SETTLE_CYCLES(S), .DEBOUNCE_CYCLES(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .col_n        (col_n),
    .row_n        (row_n),
    .key_valid    (key_valid),
    .key_value    (key_value),
    .key_is_digit (key_is_digit),
    .key_held     (key_held)
  );

  // Pressed switch shorts its column to its row when that row is driven low.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_valid) begin
      ev_val.push_back(int'(key_value));
      ev_dig.push_back(int'(key_is_digit));
      if (!key_held) noheld++;
      if (prev_v) dbl++;
    end
    prev_v = key_valid;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int ref_val(input int idx);
    string lay;
    byte   ch;
    lay = "123A456B789C*0#D";
    ch  = lay[idx];
    case (ch)
      "A": return 10;
      "B": return 11;
      "C": return 12;
      "D": return 13;
      "*": return 14;
      "#": return 15;
      default: return int'(ch) - 48;
    endcase
  endfunction

  task automatic press_until_event(input int r, input int c, input int exp_val,
                                   input int exp_dig, input string tag);
    int k, j, n0;
    k = 0;
    while (row_n[r] == 1'b0 && k < 40) begin tick; k++; end
    n0 = ev_val.size();
    pressed[r*4+c] = 1'b1;
    k = 0;
    while (row_n[r] != 1'b0 && k < 40) begin tick; k++; end
    j = 0;
    while (!key_valid && j < 60) begin tick; j++; end
    chk({tag, " latency"}, j, S + D + 1);
    chk({tag, " bound"}, int'(k + j <= 4*S + D + 3), 1);
    chk({tag, " value"}, int'(key_value), exp_val);
    chk({tag, " digit"}, int'(key_is_digit), exp_dig);
    chk({tag, " held"}, int'(key_held), 1);
    tick;
    chk({tag, " pulse"}, int'(key_valid), 0);
    chk({tag, " events"}, ev_val.size() - n0, 1);
  endtask

  task automatic release_all(input string tag);
    int m;
    pressed = '0;
    m = 0;
    while (key_held && m < 40) begin tick; m++; end
    chk({tag, " held drop"}, m, D + 2);
  endtask

  typedef struct {
    int row;
    int col;
    int hold;
    int exp_val;
    int exp_dig;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int   n0, n1, runs, run, bad_len, bad_ord, bad_hot, exp_q[$];
    logic [3:0] prev;

    tbl[0] = '{1, 2, 100, 6, 1};
    tbl[1] = '{0, 0, 20, 1, 1};
    tbl[2] = '{3, 1, 20, 0, 1};
    tbl[3] = '{3, 0, 20, 14, 0};
    tbl[4] = '{2, 3, 20, 12, 0};
    tbl[5] = '{3, 3, 20, 13, 0};

    // Reset values
    rst = 1'b1;
    repeat (3) tick;
    chk("rst row_n", int'(row_n), 4'b1110);
    chk("rst key_valid", int'(key_valid), 0);
    chk("rst key_value", int'(key_value), 0);
    chk("rst key_is_digit", int'(key_is_digit), 0);
    chk("rst key_held", int'(key_held), 0);
    rst = 1'b0;

    // Idle rotation: each row driven for S clocks in order 0,1,2,3
    n0 = ev_val.size();
    prev = row_n; run = 1; runs = 0; bad_len = 0; bad_ord = 0; bad_hot = 0;
    for (int i = 0; i < 64; i++) begin
      tick;
      if (!(row_n inside {4'b1110, 4'b1101, 4'b1011, 4'b0111})) bad_hot++;
      if (row_n == prev) run++;
      else begin
        if (row_n != {prev[2:0], prev[3]}) bad_ord++;
        if (run != S) bad_len++;
        runs++;
        run = 1;
        prev = row_n;
      end
    end
    chk("idle onehot", bad_hot, 0);
    chk("idle order", bad_ord, 0);
    chk("idle run length", bad_len, 0);
    chk("idle rotations", runs, 16);
    chk("idle events", ev_val.size() - n0, 0);

    // Directed single presses
    foreach (tbl[i]) begin
      press_until_event(tbl[i].row, tbl[i].col, tbl[i].exp_val, tbl[i].exp_dig, $sformatf("vec%0d", i));
      repeat (tbl[i].hold) tick;
      release_all($sformatf("vec%0d", i));
      repeat (6) tick;
    end

    // Bouncing "#" never survives debounce, then a stable press reports it
    n0 = ev_val.size();
    for (int i = 0; i < 6; i++) begin
      pressed[14] = ~pressed[14];
      repeat (3) tick;
    end
    pressed = '0;
    repeat (10) tick;
    chk("bounce events", ev_val.size() - n0, 0);
    press_until_event(3, 2, 15, 0, "hash");
    release_all("hash");

    // Two keys on one row: ghost, skipped, scan keeps rotating
    n0 = ev_val.size();
    pressed[0] = 1'b1;
    pressed[1] = 1'b1;
    runs = 0;
    prev = row_n;
    for (int i = 0; i < 64; i++) begin
      tick;
      if (row_n != prev) runs++;
      prev = row_n;
    end
    chk("pair rotating", int'(runs >= 12), 1);
    chk("pair events", ev_val.size() - n0, 0);
    pressed = '0;
    repeat (20) tick;

    // Second key while first is held is ignored
    press_until_event(0, 3, 10, 0, "A");
    n0 = ev_val.size();
    pressed[5] = 1'b1;
    repeat (50) tick;
    chk("held second events", ev_val.size() - n0, 0);
    release_all("A+5");
    repeat (20) tick;
    chk("after release events", ev_val.size() - n0, 0);
    press_until_event(1, 1, 5, 1, "5 again");
    release_all("5 again");
    repeat (10) tick;

    // Random clean presses and same-row pairs against the keypad model
    n0 = ev_val.size();
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        int idx;
        idx = $urandom_range(0, 15);
        pressed[idx] = 1'b1;
        exp_q.push_back(ref_val(idx));
      end else begin
        int r, c0, c1;
        r  = $urandom_range(0, 3);
        c0 = $urandom_range(0, 3);
        c1 = (c0 + 1 + $urandom_range(0, 2)) % 4;
        pressed[r*4+c0] = 1'b1;
        pressed[r*4+c1] = 1'b1;
      end
      repeat ($urandom_range(40, 80)) tick;
      pressed = '0;
      repeat ($urandom_range(20, 40)) tick;
    end
    chk("rand count", ev_val.size() - n0, exp_q.size());
    foreach (exp_q[i]) begin
      if (n0 + i < ev_val.size()) begin
        chk($sformatf("rand value %0d", i), ev_val[n0+i], exp_q[i]);
        chk($sformatf("rand digit %0d", i), ev_dig[n0+i], int'(exp_q[i] <= 9));
      end
    end

    // Reset in the middle of debouncing "8"
    n1 = 0;
    while (row_n[2] == 1'b0 && n1 < 40) begin tick; n1++; end
    pressed[9] = 1'b1;
    n1 = 0;
    while (row_n[2] != 1'b0 && n1 < 40) begin tick; n1++; end
    repeat (S + 3) tick;
    chk("debounce row held", int'(row_n), 4'b1011);
    n0 = ev_val.size();
    rst = 1'b1;
    #1;
    chk("midrst row_n", int'(row_n), 4'b1110);
    chk("midrst key_valid", int'(key_valid), 0);
    chk("midrst key_value", int'(key_value), 0);
    chk("midrst key_is_digit", int'(key_is_digit), 0);
    chk("midrst key_held", int'(key_held), 0);
    pressed = '0;
    tick;
    rst = 1'b0;
    tick;
    chk("postrst row_n", int'(row_n), 4'b1110);
    repeat (40) tick;
    chk("midrst events", ev_val.size() - n0, 0);

    chk("pulse width", dbl, 0);
    chk("held with valid", noheld, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
